// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl
//   Merges ALU results and load results onto the single register-file write
//   port. ALU results normally win the port, and load results wait in a small
//   FIFO. A starvation counter forces the FIFO head through after
//   STARVE_LIMIT consecutive cycles in which the ALU took the port. busy_o
//   tracks registers that have an outstanding load.
//
// Ports
//   clk_i, rst_i                         clock, synchronous active-high reset
//   alu_valid_i/alu_dest_i/alu_data_i    ALU result (held upstream while stalled)
//   alu_stall_o                          ALU result not taken this cycle
//   ld_valid_i/ld_ready_o/ld_dest_i/ld_data_i  load result handshake into the FIFO
//   ld_issue_i/ld_issue_dest_i           load issued to memory; marks dest busy
//   busy_o                               per-register outstanding-load flags
//   write_en_o/reg_dest_addr_o/reg_data_o  registered register-file write
module reg_writeback_ctrl #(
    parameter int WORD         = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]      alu_dest_i,
    input  logic [WORD-1:0]            alu_data_i,
    output logic                       alu_stall_o,
    input  logic                       ld_valid_i,
    output logic                       ld_ready_o,
    input  logic [ADDR_WIDTH-1:0]      ld_dest_i,
    input  logic [WORD-1:0]            ld_data_i,
    input  logic                       ld_issue_i,
    input  logic [ADDR_WIDTH-1:0]      ld_issue_dest_i,
    output logic [2**ADDR_WIDTH-1:0]   busy_o,
    output logic                       write_en_o,
    output logic [ADDR_WIDTH-1:0]      reg_dest_addr_o,
    output logic [WORD-1:0]            reg_data_o
);
    localparam int NREG  = 2**ADDR_WIDTH;
    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = $clog2(LD_DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] fifo_dest [LD_DEPTH];
    logic [WORD-1:0]       fifo_data [LD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      ld_count;
    logic [SW-1:0]         starve_cnt;

    logic                  fifo_empty, starved, alu_win, pop, push;
    logic [ADDR_WIDTH-1:0] head_dest;
    logic [WORD-1:0]       head_data;
    logic [NREG-1:0]       set_mask, clr_mask;

    // Arbitration. Everything is gated by reset so nothing moves while rst_i
    // is high, and both handshake outputs read 0 during reset.
    always_comb begin
        fifo_empty  = (ld_count == '0);
        starved     = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
        alu_win     = !rst_i && alu_valid_i && !starved;
        pop         = !rst_i && !fifo_empty && (starved || !alu_valid_i);
        alu_stall_o = !rst_i && alu_valid_i && starved;
        // Readiness depends only on occupancy. A full FIFO refuses a push
        // even when it pops in the same cycle.
        ld_ready_o  = !rst_i && (ld_count < CNT_W'(LD_DEPTH));
        push        = ld_valid_i && ld_ready_o;
        head_dest   = fifo_dest[rd_ptr];
        head_data   = fifo_data[rd_ptr];
        set_mask    = ld_issue_i ? (NREG'(1) << ld_issue_dest_i) : '0;
        clr_mask    = pop ? (NREG'(1) << head_dest) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_dest[wr_ptr] <= ld_dest_i;
            fifo_data[wr_ptr] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ld_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   ld_count <= ld_count + 1'b1;
                2'b01:   ld_count <= ld_count - 1'b1;
                default: ld_count <= ld_count;
            endcase
        end
    end

    // The counter tracks consecutive cycles in which a waiting load lost the
    // port to the ALU. It is cleared by any pop and whenever nothing waits.
    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_empty || pop)
            starve_cnt <= '0;
        else if (alu_win && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // A new issue to a register is set after the pop of an older load to the
    // same register is cleared, so the set wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) busy_o <= '0;
        else       busy_o <= (busy_o & ~clr_mask) | set_mask;
    end

    // The address and data registers keep their values on idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_en_o      <= 1'b0;
            reg_dest_addr_o <= '0;
            reg_data_o      <= '0;
        end else if (alu_win) begin
            write_en_o      <= 1'b1;
            reg_dest_addr_o <= alu_dest_i;
            reg_data_o      <= alu_data_i;
        end else if (pop) begin
            write_en_o      <= 1'b1;
            reg_dest_addr_o <= head_dest;
            reg_data_o      <= head_data;
        end else begin
            write_en_o      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Testbench for reg_writeback_ctrl. A queue-based reference model in the
// compare process is checked against the DUT on every falling edge. Directed
// scenarios also check hand-computed literal values.
module tb_reg_writeback_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [3:0]  alu_dest_i;
    logic [31:0] alu_data_i;
    logic        alu_stall_o;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [3:0]  ld_dest_i;
    logic [31:0] ld_data_i;
    logic        ld_issue_i;
    logic [3:0]  ld_issue_dest_i;
    logic [15:0] busy_o;
    logic        write_en_o;
    logic [3:0]  reg_dest_addr_o;
    logic [31:0] reg_data_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    reg_writeback_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_dest_i(alu_dest_i), .alu_data_i(alu_data_i),
        .alu_stall_o(alu_stall_o),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_dest_i(ld_dest_i),
        .ld_data_i(ld_data_i),
        .ld_issue_i(ld_issue_i), .ld_issue_dest_i(ld_issue_dest_i),
        .busy_o(busy_o), .write_en_o(write_en_o),
        .reg_dest_addr_o(reg_dest_addr_o), .reg_data_o(reg_data_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Each queue entry is {dest, data}. m_* values are the
    // registered outputs expected after the next rising edge.
    logic [35:0] mq[$];
    logic [15:0] m_busy;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    int          m_starve;
    bit          m_ok = 0;

    always @(negedge clk_i) begin
        bit          starved, rdy;
        logic [35:0] hd;
        if (m_ok) begin
            chk("write_en", write_en_o, m_we);
            chk("dest_addr", reg_dest_addr_o, m_addr);
            chk("data", reg_data_o, m_data);
            chk("busy", busy_o, m_busy);
        end
        if (m_ok || rst_i) begin
            starved = (mq.size() > 0) && (m_starve == 4);
            rdy     = !rst_i && (mq.size() < 2);
            chk("ld_ready", ld_ready_o, rdy);
            chk("alu_stall", alu_stall_o, !rst_i && alu_valid_i && starved);
            if (rst_i) begin
                mq.delete();
                m_busy = '0; m_we = 0; m_addr = '0; m_data = '0; m_starve = 0;
                m_ok = 1;
            end else begin
                bit was_empty;
                was_empty = (mq.size() == 0);
                if (alu_valid_i && !starved) begin
                    m_we = 1; m_addr = alu_dest_i; m_data = alu_data_i;
                    if (!was_empty && m_starve < 4) m_starve++;
                end else if (!was_empty) begin
                    hd = mq.pop_front();
                    m_we = 1; m_addr = hd[35:32]; m_data = hd[31:0];
                    m_busy[hd[35:32]] = 1'b0;
                    m_starve = 0;
                end else begin
                    m_we = 0;
                end
                if (was_empty) m_starve = 0;
                if (ld_issue_i) m_busy[ld_issue_dest_i] = 1'b1;
                if (ld_valid_i && rdy) mq.push_back({ld_dest_i, ld_data_i});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1; alu_valid_i = 0; alu_dest_i = 0; alu_data_i = 0;
        ld_valid_i = 0; ld_dest_i = 0; ld_data_i = 0; ld_issue_i = 0; ld_issue_dest_i = 0;
        cyc(); cyc();
        chk("rst_busy", busy_o, 16'h0);
        chk("rst_we", write_en_o, 1'b0);
        chk("rst_ready", ld_ready_o, 1'b0);
        rst_i = 0; #1;
        chk("ready_after_rst", ld_ready_o, 1'b1);

        // ALU-only write
        alu_valid_i = 1; alu_dest_i = 3; alu_data_i = 32'hDEADBEEF; #1;
        chk("alu_no_stall", alu_stall_o, 1'b0);
        cyc(); alu_valid_i = 0;
        chk("alu_we", write_en_o, 1'b1);
        chk("alu_addr", reg_dest_addr_o, 4'd3);
        chk("alu_data", reg_data_o, 32'hDEADBEEF);
        cyc();
        chk("idle_we", write_en_o, 1'b0);
        chk("idle_hold", reg_data_o, 32'hDEADBEEF);

        // Load path: issue, handshake, pop
        ld_issue_i = 1; ld_issue_dest_i = 5; cyc(); ld_issue_i = 0;
        chk("busy5_set", busy_o, 16'h0020);
        ld_valid_i = 1; ld_dest_i = 5; ld_data_i = 32'h12; cyc(); ld_valid_i = 0;
        cyc();
        chk("ld_we", write_en_o, 1'b1);
        chk("ld_addr", reg_dest_addr_o, 4'd5);
        chk("ld_data", reg_data_o, 32'h12);
        chk("busy5_clr", busy_o[5], 1'b0);

        // FIFO fills while the ALU holds the port; starvation forces a pop
        alu_valid_i = 1; alu_dest_i = 9; alu_data_i = 32'h100;
        ld_valid_i = 1; ld_dest_i = 1; ld_data_i = 32'hA1; cyc();
        alu_data_i = 32'h101; ld_dest_i = 2; ld_data_i = 32'hA2; cyc();
        ld_valid_i = 0; alu_data_i = 32'h102;
        chk("full_ready", ld_ready_o, 1'b0);
        cyc(); cyc(); chk("not_yet_stall", alu_stall_o, 1'b0);
        cyc();
        chk("starve_stall", alu_stall_o, 1'b1);
        cyc();
        chk("starve_addr", reg_dest_addr_o, 4'd1);
        chk("starve_data", reg_data_o, 32'hA1);
        chk("stall_one_cycle", alu_stall_o, 1'b0);
        chk("ready_again", ld_ready_o, 1'b1);
        alu_valid_i = 0; cyc(); cyc();

        // Set/clear collision on register 7
        ld_issue_i = 1; ld_issue_dest_i = 7; cyc(); ld_issue_i = 0;
        ld_valid_i = 1; ld_dest_i = 7; ld_data_i = 32'h77; cyc(); ld_valid_i = 0;
        ld_issue_i = 1; ld_issue_dest_i = 7; cyc(); ld_issue_i = 0;
        chk("collide_busy7", busy_o[7], 1'b1);
        chk("collide_addr", reg_dest_addr_o, 4'd7);
        cyc();

        // Pseudo-random traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            rst_i           = ($urandom_range(0, 59) == 0);
            alu_valid_i     = $urandom_range(0, 1);
            alu_dest_i      = 4'($urandom);
            alu_data_i      = $urandom;
            ld_valid_i      = $urandom_range(0, 1);
            ld_dest_i       = 4'($urandom);
            ld_data_i       = $urandom;
            ld_issue_i      = ($urandom_range(0, 2) == 0);
            ld_issue_dest_i = 4'($urandom);
            cyc();
        end
        alu_valid_i = 0; ld_valid_i = 0; ld_issue_i = 0;
        rst_i = 1; cyc(); rst_i = 0;

        // Reset mid-operation with a full FIFO and busy = 0x0021
        ld_issue_i = 1; ld_issue_dest_i = 0; cyc();
        ld_issue_dest_i = 5; cyc(); ld_issue_i = 0;
        alu_valid_i = 1; alu_dest_i = 4; alu_data_i = 32'h44;
        ld_valid_i = 1; ld_dest_i = 0; ld_data_i = 32'hAA; cyc();
        ld_dest_i = 5; ld_data_i = 32'hBB; cyc(); ld_valid_i = 0;
        chk("pre_rst_busy", busy_o, 16'h0021);
        chk("pre_rst_full", ld_ready_o, 1'b0);
        rst_i = 1; #1;
        chk("rst_no_stall", alu_stall_o, 1'b0);
        chk("rst_ready0", ld_ready_o, 1'b0);
        cyc(); rst_i = 0; alu_valid_i = 0;
        chk("mid_rst_busy", busy_o, 16'h0);
        chk("mid_rst_we", write_en_o, 1'b0);
        #1 chk("mid_rst_ready", ld_ready_o, 1'b1);
        cyc(); chk("no_stale_1", write_en_o, 1'b0);
        cyc(); chk("no_stale_2", write_en_o, 1'b0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 Parameter WORD, default 32: register data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4: register address width, giving 16 registers.
REQ-003 Parameter LD_DEPTH, default 2: load-result FIFO entries, power of two, at least 2.
REQ-004 Parameter STARVE_LIMIT, default 4: count of consecutive ALU-preempted cycles after which the FIFO head SHALL win arbitration.
REQ-005 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 alu_valid_i  input  1  ALU result present this cycle.
REQ-008 alu_dest_i  input  ADDR_WIDTH  ALU destination register.
REQ-009 alu_data_i  input  WORD  ALU result.
REQ-010 alu_stall_o  output  1  combinational; ALU result not taken this cycle, and upstream SHALL hold it.
REQ-011 ld_valid_i  input  1  load result offered.
REQ-012 ld_ready_o  output  1  FIFO can accept; transfer occurs when ld_valid_i and ld_ready_o are both 1.
REQ-013 ld_dest_i  input  ADDR_WIDTH  load destination register.
REQ-014 ld_data_i  input  WORD  load data.
REQ-015 ld_issue_i  input  1  a load has been issued to memory.
REQ-016 ld_issue_dest_i  input  ADDR_WIDTH  destination of the issued load.
REQ-017 busy_o  output  2**ADDR_WIDTH  registered; bit n set means a load to register n is outstanding.
REQ-018 write_en_o  output  1  registered write strobe to the register file.
REQ-019 reg_dest_addr_o  output  ADDR_WIDTH  registered write address.
REQ-020 reg_data_o  output  WORD  registered write data.

Function
REQ-021 Every accepted load result SHALL be pushed into the FIFO; loads SHALL never write the register file directly.
REQ-022 ld_ready_o SHALL be 1 only when rst_i is 0 and the FIFO occupancy is below LD_DEPTH.
REQ-023 A pop and a push in the same cycle SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Arbitration each cycle: if the FIFO is non-empty and starve_cnt equals STARVE_LIMIT, pop the head, and alu_stall_o SHALL be 1 if alu_valid_i is 1.
REQ-025 Otherwise, if alu_valid_i is 1, the ALU result SHALL win and alu_stall_o SHALL be 0.
REQ-026 Otherwise, if the FIFO is non-empty, the head SHALL be popped.
REQ-027 Otherwise no write SHALL be selected.
REQ-028 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in any cycle the FIFO is non-empty and the ALU wins.
REQ-029 starve_cnt SHALL clear on any FIFO pop and whenever the FIFO is empty.
REQ-030 The selected write SHALL appear on write_en_o, reg_dest_addr_o and reg_data_o exactly one cycle later.
REQ-031 In a cycle with no selected write, write_en_o SHALL be 0 and reg_dest_addr_o and reg_data_o SHALL hold their previous values.
REQ-032 A load-result write is committed in the cycle its FIFO pop is selected; that commit SHALL clear busy bit ld_dest.
REQ-033 ld_issue_i SHALL set busy bit ld_issue_dest_i at the next clock edge.
REQ-034 If a set and a clear target the same bit in one cycle, the set SHALL win.
REQ-035 ALU writes SHALL NOT modify busy_o, including writes to a register that is busy.
REQ-036 At most one register-file write SHALL be issued per cycle.
REQ-037 Minimum latency from a load handshake to write_en_o is 2 cycles.
REQ-038 Minimum latency from an ALU result to write_en_o is 1 cycle.

Reset
REQ-039 While rst_i is 1, at each clock edge: FIFO occupancy cleared, starve_cnt set to 0, busy_o set to 0, write_en_o set to 0, reg_dest_addr_o set to 0, reg_data_o set to 0.
REQ-040 While rst_i is 1, ld_ready_o and alu_stall_o SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL discard all FIFO contents and outstanding busy bits; no write SHALL be issued in the cycle after reset.
REQ-042 ld_ready_o SHALL be 1 in the first cycle rst_i is 0.

Verification
REQ-043 ALU only: alu_valid_i=1, alu_dest_i=3, alu_data_i=0xDEADBEEF -> next cycle write_en_o=1, reg_dest_addr_o=3, reg_data_o=0xDEADBEEF; alu_stall_o stays 0.
REQ-044 Load path: ld_issue_i with ld_issue_dest_i=5 -> busy_o[5]=1; then load handshake with dest 5, data 0x12 and ALU idle -> write of 0x12 to register 5 two cycles after the handshake; busy_o[5]=0 one cycle after the pop.
REQ-045 FIFO full: two loads accepted while ALU is valid every cycle -> ld_ready_o=0; after 4 preempted cycles, alu_stall_o=1 for one cycle and the head load is written.
REQ-046 Set/clear collision: the pop of a load to register 7 coincides with ld_issue_i to register 7 -> busy_o[7] remains 1.
REQ-047 Reset mid-operation: FIFO holds 2 entries and busy_o=0x0021, rst_i pulsed for one cycle -> busy_o=0, write_en_o=0 the following cycle, ld_ready_o=1 once rst_i is low, and no stale write ever issues.
